// File: rtl/lsu_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_initiator
// Purpose  : Load/store initiator between the execute stage and the
//            byte-addressed data RAM. Takes one request over valid/ready,
//            drives exactly one RAM access and returns extended load data or
//            a fault on a registered valid/ready response channel.
// Options  : LSU_MISALIGN_SPLIT_EN - misaligned legal H/HU/W requests are
//            broken into consecutive byte accesses instead of faulting.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_initiator #(
  parameter int RAM_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [RAM_WIDTH:0]   req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_rdata,
  output logic                 resp_fault,
  output logic [2:0]           mem_rw_len,
  output logic [RAM_WIDTH:0]   mem_addr,
  output logic [31:0]          mem_write,
  input  logic [31:0]          mem_read,
  input  logic                 mem_exception
);

  localparam int AW = RAM_WIDTH + 1;

`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    SPLIT  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
`endif

  state_t      state;
  state_t      state_next;

  logic        lat_we;
  logic [2:0]  lat_funct3;

  logic        pre_illegal;
  logic        pre_misaligned;
  logic        pre_fault;

  // Sign/zero extension by access size; funct3[2] selects unsigned
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] f);
    logic [31:0] r;
    case (f[1:0])
      2'b00:   r = {{24{d[7]  & ~f[2]}}, d[7:0]};
      2'b01:   r = {{16{d[15] & ~f[2]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Request precheck, evaluated on the incoming request so a fault can reach
  // RESP one cycle after acceptance
  assign pre_illegal = (req_funct3 == 3'b011) ||
                       (req_funct3[2:1] == 2'b11) ||
                       ((req_funct3[2:1] == 2'b10) && req_we);
  assign pre_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [1:0]  pre_last;
  logic [AW:0] pre_end;
  logic        pre_overflow;
  logic        pre_split;
  logic [31:0] lat_wdata;
  logic [1:0]  split_cnt;
  logic [1:0]  split_cnt_nxt;
  logic [1:0]  split_last;
  logic [31:0] split_acc;
  logic [31:0] split_word;

  // A split covers addr..addr+n-1; the carry out flags a run past the top of RAM
  assign pre_last     = (req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
  assign pre_end      = {1'b0, req_addr} + {{(AW-1){1'b0}}, pre_last};
  assign pre_overflow = pre_end[AW];
  assign pre_split    = pre_misaligned && !pre_illegal && !pre_overflow;
  assign pre_fault    = pre_illegal || (pre_misaligned && pre_overflow);

  assign split_cnt_nxt = split_cnt + 2'd1;
  assign split_last    = (lat_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;

  // Merge the byte arriving this cycle into its lane of the partial load word
  always_comb begin
    split_word = split_acc;
    split_word[{split_cnt, 3'b000} +: 8] = mem_read[7:0];
  end
`else
  assign pre_fault = pre_illegal || pre_misaligned;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, handshake and RAM command decode; the write bit is masked
  // while rst is high so a reset landing on an access never stores
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_rw_len = 3'b000;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (pre_fault) begin
            state_next = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
          end else if (pre_split) begin
            state_next = SPLIT;
`endif
          end else begin
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!rst) begin
          mem_rw_len = {lat_we, lat_funct3[1:0]};
        end
        state_next = RESP;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      SPLIT: begin
        if (!rst) begin
          mem_rw_len = {lat_we, 2'b00};
        end
        if (mem_exception || (split_cnt == split_last)) begin
          state_next = RESP;
        end
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, RAM address/data registers and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we     <= 1'b0;
      lat_funct3 <= 3'b000;
      mem_addr   <= '0;
      mem_write  <= 32'h0;
      resp_rdata <= 32'h0;
      resp_fault <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      lat_wdata  <= 32'h0;
      split_cnt  <= 2'd0;
      split_acc  <= 32'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
`ifdef LSU_MISALIGN_SPLIT_EN
            lat_wdata  <= req_wdata;
            split_cnt  <= 2'd0;
            split_acc  <= 32'h0;
`endif
            if (pre_fault) begin
              resp_rdata <= 32'h0;
              resp_fault <= 1'b1;
            end else begin
              // RAM address/data only move when an access is really issued
              mem_addr <= req_addr;
`ifdef LSU_MISALIGN_SPLIT_EN
              if (pre_split) begin
                mem_write <= {24'h0, req_wdata[7:0]};
              end else begin
                mem_write <= req_wdata;
              end
`else
              mem_write <= req_wdata;
`endif
            end
          end
        end
        ACCESS: begin
          resp_fault <= mem_exception;
          if (lat_we || mem_exception) begin
            resp_rdata <= 32'h0;
          end else begin
            resp_rdata <= extend(mem_read, lat_funct3);
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        SPLIT: begin
          if (mem_exception) begin
            resp_fault <= 1'b1;
            resp_rdata <= 32'h0;
          end else if (split_cnt == split_last) begin
            resp_fault <= 1'b0;
            resp_rdata <= lat_we ? 32'h0 : extend(split_word, lat_funct3);
          end else begin
            split_cnt <= split_cnt_nxt;
            split_acc <= split_word;
            mem_addr  <= mem_addr + {{(AW-1){1'b0}}, 1'b1};
            mem_write <= {24'h0, lat_wdata[{split_cnt_nxt, 3'b000} +: 8]};
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_initiator
// Purpose  : Directed self-checking bench for lsu_mem_initiator. Expected
//            values are hand-computed per vector. Split-mode vectors are
//            selected when LSU_MISALIGN_SPLIT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_initiator;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_fault;
  logic [2:0]    mem_rw_len;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_write;
  logic [31:0]   mem_read;
  logic          mem_exception;

  // RAM stand-in: either a fixed word or a small byte array indexed by address
  logic [31:0]   rd_val;
  logic          use_bytes;
  logic [7:0]    byte_mem [0:7];

  int            n_checks = 0;
  int            n_fail   = 0;

  // Per-request observations
  int            lat;
  int            nwr;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [2:0]    wr_len;
  logic [AW-1:0] addr_log [0:7];
  logic [31:0]   got_rdata;
  logic          got_fault;

  assign mem_read = use_bytes ? {24'h0, byte_mem[mem_addr[2:0]]} : rd_val;

  lsu_mem_initiator #(.RAM_WIDTH(AW-1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_rw_len   (mem_rw_len),
    .mem_addr     (mem_addr),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .mem_exception(mem_exception)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".req_ready"},  {31'h0, req_ready},  32'h1);
    check_val({tag, ".resp_valid"}, {31'h0, resp_valid}, 32'h0);
    check_val({tag, ".resp_rdata"}, resp_rdata,          32'h0);
    check_val({tag, ".resp_fault"}, {31'h0, resp_fault}, 32'h0);
    check_val({tag, ".mem_rw_len"}, {29'h0, mem_rw_len}, 32'h0);
    check_val({tag, ".mem_addr"},   {21'h0, mem_addr},   32'h0);
    check_val({tag, ".mem_write"},  mem_write,           32'h0);
  endtask

  // Present one request in cycle 0, log RAM activity until resp_valid, then
  // capture the response and let resp_ready (held 1) consume it
  task automatic run_req(input logic we, input logic [2:0] f3,
                         input logic [AW-1:0] addr, input logic [31:0] wd);
    int cyc;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    nwr = 0;
    cyc = 0;
    for (int i = 0; i < 8; i++) addr_log[i] = '0;
    while (!resp_valid && cyc < 20) begin
      if (mem_rw_len[2]) begin
        nwr++;
        wr_addr = mem_addr;
        wr_data = mem_write;
        wr_len  = mem_rw_len;
      end
      if (cyc < 8) addr_log[cyc] = mem_addr;
      tick();
      req_valid = 1'b0;
      cyc++;
    end
    lat = cyc;
    check_val("resp_valid_seen", {31'h0, resp_valid}, 32'h1);
    got_rdata = resp_rdata;
    got_fault = resp_fault;
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = 32'h0; resp_ready = 1'b1;
    rd_val = 32'h0; use_bytes = 1'b0; mem_exception = 1'b0;
    byte_mem[0] = 8'h00; byte_mem[1] = 8'h11; byte_mem[2] = 8'h22; byte_mem[3] = 8'h33;
    byte_mem[4] = 8'h44; byte_mem[5] = 8'h55; byte_mem[6] = 8'h66; byte_mem[7] = 8'h77;
    wr_addr = '0; wr_data = 32'h0; wr_len = 3'b000;

    tick(); tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // LB at 0x004, byte 0x80 sign-extended
    rd_val = 32'h12345680;
    run_req(1'b0, 3'b000, 11'h004, 32'h0);
    check_val("lb.lat",   lat,       2);
    check_val("lb.rdata", got_rdata, 32'hFFFFFF80);
    check_val("lb.fault", {31'h0, got_fault}, 32'h0);
    check_val("lb.addr",  {21'h0, addr_log[1]}, 32'h004);
    check_val("lb.nwr",   nwr,       0);
    check_val("idle.req_ready", {31'h0, req_ready}, 32'h1);

    // LHU / LH at 0x006, half 0x8001
    rd_val = 32'hABCD8001;
    run_req(1'b0, 3'b101, 11'h006, 32'h0);
    check_val("lhu.rdata", got_rdata, 32'h00008001);
    run_req(1'b0, 3'b001, 11'h006, 32'h0);
    check_val("lh.rdata",  got_rdata, 32'hFFFF8001);

    // BU and W
    rd_val = 32'hDEADBEEF;
    run_req(1'b0, 3'b100, 11'h005, 32'h0);
    check_val("lbu.rdata", got_rdata, 32'h000000EF);
    run_req(1'b0, 3'b010, 11'h008, 32'h0);
    check_val("lw.rdata",  got_rdata, 32'hDEADBEEF);

    // SW at 0x010: exactly one write cycle
    rd_val = 32'h55555555;
    run_req(1'b1, 3'b010, 11'h010, 32'hDEADBEEF);
    check_val("sw.nwr",   nwr,               1);
    check_val("sw.len",   {29'h0, wr_len},   32'h6);
    check_val("sw.addr",  {21'h0, wr_addr},  32'h010);
    check_val("sw.data",  wr_data,           32'hDEADBEEF);
    check_val("sw.rdata", got_rdata,         32'h0);
    check_val("sw.fault", {31'h0, got_fault}, 32'h0);
    check_val("sw.lat",   lat,               2);

`ifdef LSU_MISALIGN_SPLIT_EN
    // SH at 0x003 becomes two byte writes at 0x003, 0x004
    run_req(1'b1, 3'b001, 11'h003, 32'h0000A55A);
    check_val("sh_split.lat",   lat,              3);
    check_val("sh_split.nwr",   nwr,              2);
    check_val("sh_split.addr",  {21'h0, wr_addr}, 32'h004);
    check_val("sh_split.data",  wr_data,          32'h000000A5);
    check_val("sh_split.len",   {29'h0, wr_len},  32'h4);
    check_val("sh_split.fault", {31'h0, got_fault}, 32'h0);

    // LW at 0x001 assembled from four byte reads
    use_bytes = 1'b1;
    run_req(1'b0, 3'b010, 11'h001, 32'h0);
    check_val("lw_split.lat",   lat,                  5);
    check_val("lw_split.rdata", got_rdata,            32'h44332211);
    check_val("lw_split.a1",    {21'h0, addr_log[1]}, 32'h001);
    check_val("lw_split.a4",    {21'h0, addr_log[4]}, 32'h004);
    use_bytes = 1'b0;

    // Word split running past the top of RAM faults without access
    run_req(1'b0, 3'b010, 11'h7FE, 32'h0);
    check_val("split_ovf.lat",   lat,               1);
    check_val("split_ovf.fault", {31'h0, got_fault}, 32'h1);
`else
    // SH at 0x003 faults in the precheck, no write
    run_req(1'b1, 3'b001, 11'h003, 32'h0000A55A);
    check_val("sh_mis.lat",   lat,               1);
    check_val("sh_mis.fault", {31'h0, got_fault}, 32'h1);
    check_val("sh_mis.nwr",   nwr,               0);
    check_val("sh_mis.rdata", got_rdata,         32'h0);
    run_req(1'b0, 3'b010, 11'h00A, 32'h0);
    check_val("lw_mis.fault", {31'h0, got_fault}, 32'h1);
`endif

    // Illegal funct3 values
    run_req(1'b0, 3'b011, 11'h000, 32'h0);
    check_val("f011.fault", {31'h0, got_fault}, 32'h1);
    check_val("f011.lat",   lat,               1);
    run_req(1'b1, 3'b100, 11'h000, 32'hFFFFFFFF);
    check_val("sbu.fault",  {31'h0, got_fault}, 32'h1);
    check_val("sbu.nwr",    nwr,               0);
    run_req(1'b0, 3'b110, 11'h000, 32'h0);
    check_val("f110.fault", {31'h0, got_fault}, 32'h1);

    // RAM exception during the access
    rd_val = 32'h12345678;
    mem_exception = 1'b1;
    run_req(1'b0, 3'b010, 11'h00C, 32'h0);
    mem_exception = 1'b0;
    check_val("exc.fault", {31'h0, got_fault}, 32'h1);
    check_val("exc.rdata", got_rdata,          32'h0);

    // Back-pressure: response held for 5 cycles, new request not taken
    resp_ready = 1'b0;
    rd_val = 32'h0000007F;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 11'h004;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check_val("hold.resp_valid", {31'h0, resp_valid}, 32'h1);
      check_val("hold.rdata",      resp_rdata,          32'h0000007F);
      check_val("hold.req_ready",  {31'h0, req_ready},  32'h0);
      rd_val = 32'hFFFFFFFF;
      req_valid = 1'b1;
      tick();
    end
    resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    check_val("consume.resp_valid", {31'h0, resp_valid}, 32'h0);
    check_val("consume.req_ready",  {31'h0, req_ready},  32'h1);

    // Reset during the access cycle of a SW
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 11'h020; req_wdata = 32'h12345678;
    tick();
    req_valid = 1'b0;
    check_val("rstsw.len_before", {29'h0, mem_rw_len}, 32'h6);
    rst = 1'b1;
    #1;
    check_val("rstsw.no_write", {31'h0, mem_rw_len[2]}, 32'h0);
    tick();
    rst = 1'b0;
    check_reset_outputs("rstsw");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
